sccb_responder: RTL

SCCB_RESPONDER -- requirements
Module: sccb_responder

---
 rtl/sccb_responder.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/sccb_responder.sv
`default_nettype none
// ============================================================================
//  Module   : sccb_responder
//  Purpose  : SCCB (I2C-like) camera register responder. Oversamples the
//             sioc/siod lines on camera_clk, decodes 3-phase writes
//             (ID, sub-address, data) and 2-phase write + read sequences.
//             siod is open-drain: siod_oe=1 pulls the line low.
//  Ports    : camera_clk, rst  - clock, synchronous active-high reset
//             sioc, siod_in    - asynchronous SCCB lines from the bus
//             siod_oe          - open-drain pull-down enable
//             wr_valid/addr/data - completed register write
//             rd_addr/rd_data  - sub-address pointer and host read data
//             busy             - START seen, STOP not yet seen
//  Config   : define SCCB_ACK_DRIVE_EN to pull siod low during the ninth
//             (don't-care/ACK) bit of ID (on match), SUB and DATA bytes.
//  Revision : 1.0 - initial release
// ============================================================================
module sccb_responder #(
    parameter logic [7:0] DEVICE_ADDR = 8'h60
) (
    input  logic       camera_clk,
    input  logic       rst,
    input  logic       sioc,
    input  logic       siod_in,
    output logic       siod_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy
);

`ifdef SCCB_ACK_DRIVE_EN
    localparam logic c_ACK_DRIVE = 1'b1;
`else
    localparam logic c_ACK_DRIVE = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ID      = 4'd1,
        S_ID_X    = 4'd2,
        S_SUB     = 4'd3,
        S_SUB_X   = 4'd4,
        S_DATA    = 4'd5,
        S_DATA_X  = 4'd6,
        S_RDATA   = 4'd7,
        S_RDATA_X = 4'd8,
        S_IGNORE  = 4'd9
    } state_t;

    // ---------------- synchronizers + edge detector ----------------
    logic [1:0] sioc_sync_q;
    logic [1:0] siod_sync_q;
    logic       sioc_prev_q;
    logic       siod_prev_q;

    always_ff @(posedge camera_clk) begin
        if (rst) begin
            sioc_sync_q <= 2'b11;
            siod_sync_q <= 2'b11;
            sioc_prev_q <= 1'b1;
            siod_prev_q <= 1'b1;
        end else begin
            sioc_sync_q <= {sioc_sync_q[0], sioc};
            siod_sync_q <= {siod_sync_q[0], siod_in};
            sioc_prev_q <= sioc_sync_q[1];
            siod_prev_q <= siod_sync_q[1];
        end
    end

    logic w_sioc;
    logic w_siod;
    logic w_start;
    logic w_stop;
    logic w_rise;
    logic w_fall;

    assign w_sioc  = sioc_sync_q[1];
    assign w_siod  = siod_sync_q[1];
    assign w_start = w_sioc & siod_prev_q & ~w_siod;
    assign w_stop  = w_sioc & ~siod_prev_q & w_siod;
    assign w_rise  = w_sioc & ~sioc_prev_q;
    assign w_fall  = ~w_sioc & sioc_prev_q;

    // ---------------- protocol FSM ----------------
    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] shift_q;
    logic       rw_q;
    logic       xbit_seen_q;   // sioc rise of the ninth bit already seen
    logic       siod_oe_q;
    logic       wr_valid_q;
    logic [7:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic [7:0] rd_addr_q;
    logic       busy_q;

    logic [7:0] w_byte;
    logic       w_last;

    assign w_byte = {shift_q, w_siod};
    assign w_last = (bit_cnt_q == 3'd7);

    always_ff @(posedge camera_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
            rw_q        <= 1'b0;
            xbit_seen_q <= 1'b0;
            siod_oe_q   <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= 8'd0;
            wr_data_q   <= 8'd0;
            rd_addr_q   <= 8'd0;
            busy_q      <= 1'b0;
        end else begin
            wr_valid_q <= 1'b0;
            if (w_start) begin
                // Also covers repeated START in the middle of a transfer.
                state_q   <= S_ID;
                bit_cnt_q <= 3'd0;
                siod_oe_q <= 1'b0;
                busy_q    <= 1'b1;
            end else if (w_stop) begin
                state_q   <= S_IDLE;
                bit_cnt_q <= 3'd0;
                siod_oe_q <= 1'b0;
                busy_q    <= 1'b0;
            end else if (w_rise) begin
                case (state_q)
                    S_ID, S_SUB, S_DATA: begin
                        shift_q   <= w_byte[6:0];
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (w_last) begin
                            xbit_seen_q <= 1'b0;
                            case (state_q)
                                S_ID: begin
                                    if (w_byte[7:1] != DEVICE_ADDR[7:1]) begin
                                        state_q <= S_IGNORE;
                                    end else begin
                                        state_q <= S_ID_X;
                                        rw_q    <= w_byte[0];
                                    end
                                end
                                S_SUB: begin
                                    rd_addr_q <= w_byte;
                                    state_q   <= S_SUB_X;
                                end
                                default: begin
                                    wr_addr_q  <= rd_addr_q;
                                    wr_data_q  <= w_byte;
                                    wr_valid_q <= 1'b1;
                                    state_q    <= S_DATA_X;
                                end
                            endcase
                        end
                    end
                    S_RDATA: begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (w_last) begin
                            xbit_seen_q <= 1'b0;
                            state_q     <= S_RDATA_X;
                        end
                    end
                    S_ID_X, S_SUB_X, S_DATA_X, S_RDATA_X: begin
                        xbit_seen_q <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (w_fall) begin
                // The first fall in an X state opens the ninth bit; the
                // second (after its rise) closes it and leaves the state.
                case (state_q)
                    S_ID_X: begin
                        if (!xbit_seen_q) begin
                            siod_oe_q <= c_ACK_DRIVE;
                        end else if (rw_q) begin
                            state_q   <= S_RDATA;
                            bit_cnt_q <= 3'd0;
                            siod_oe_q <= ~rd_data[7];
                        end else begin
                            state_q   <= S_SUB;
                            bit_cnt_q <= 3'd0;
                            siod_oe_q <= 1'b0;
                        end
                    end
                    S_SUB_X: begin
                        if (!xbit_seen_q) begin
                            siod_oe_q <= c_ACK_DRIVE;
                        end else begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= 3'd0;
                            siod_oe_q <= 1'b0;
                        end
                    end
                    S_DATA_X: begin
                        if (!xbit_seen_q) begin
                            siod_oe_q <= c_ACK_DRIVE;
                        end else begin
                            state_q   <= S_IGNORE;
                            siod_oe_q <= 1'b0;
                        end
                    end
                    S_RDATA_X: begin
                        // Master's NA bit is not examined.
                        siod_oe_q <= 1'b0;
                        if (xbit_seen_q) begin
                            state_q <= S_IGNORE;
                        end
                    end
                    S_RDATA: begin
                        // 7-n for a 3-bit n is its bitwise inverse.
                        siod_oe_q <= ~rd_data[~bit_cnt_q];
                    end
                    default: begin
                        siod_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign siod_oe  = siod_oe_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign rd_addr  = rd_addr_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire
